stp_frame_rx: RTL and testbench

STP_FRAME_RX -- requirements
Module: stp_frame_rx

---
 rtl/stp_frame_rx.sv | 108 ++++++++++
 tb/tb_stp_frame_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stp_frame_rx.sv
// Serial frame receiver: start(0), BIT_WIDTH data bits MSB first, stop(1), one bit per shift_strobe.
// Latency: rx_data/data_ready/framing_error update on the edge that samples the stop bit.
// Backpressure: none; an unread word is overwritten and flagged by overrun_error until data_read.
module stp_frame_rx #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 shift_strobe,
    input  logic                 data_read,
    output logic [BIT_WIDTH-1:0] rx_data,
    output logic                 data_ready,
    output logic                 framing_error,
    output logic                 overrun_error
);
    localparam int CW = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BIT_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic                 rdy_q, rdy_d;
    logic                 fe_q, fe_d;
    logic                 ovr_q, ovr_d;
    logic                 load;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            rdy_q   <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            rdy_q   <= rdy_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        rdy_d   = rdy_q;
        fe_d    = fe_q;
        ovr_d   = ovr_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (shift_strobe && !serial_in) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    fe_d    = 1'b0;
                end
            end
            DATA: begin
                if (shift_strobe) begin
                    shift_d = {shift_q[BIT_WIDTH-2:0], serial_in};
                    // Counter parks at LAST so it never exceeds BIT_WIDTH-1.
                    if (cnt_q == LAST) begin
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            STOP: begin
                if (shift_strobe) begin
                    state_d = IDLE;
                    if (serial_in) begin
                        load = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A read coinciding with a load consumes the old word, so no overrun.
        if (load) begin
            data_d = shift_q;
            rdy_d  = 1'b1;
            ovr_d  = data_read ? 1'b0 : (ovr_q | rdy_q);
        end else if (data_read) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
        end
    end

    assign rx_data       = data_q;
    assign data_ready    = rdy_q;
    assign framing_error = fe_q;
    assign overrun_error = ovr_q;
endmodule

// File: tb/tb_stp_frame_rx.sv
// Bench for stp_frame_rx: frame-level reference model compared every cycle,
// plus literal expectations for directed frames and randomized traffic.
module tb_stp_frame_rx;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         serial_in = 1'b1;
    logic         shift_strobe = 1'b0;
    logic         data_read = 1'b0;
    logic [W-1:0] rx_data;
    logic         data_ready;
    logic         framing_error;
    logic         overrun_error;

    stp_frame_rx #(.BIT_WIDTH(W)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .serial_in     (serial_in),
        .shift_strobe  (shift_strobe),
        .data_read     (data_read),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .framing_error (framing_error),
        .overrun_error (overrun_error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    // Reference model: bits collected since the start bit, decoded once complete.
    bit           m_in_frame;
    bit           m_bits[$];
    logic [W-1:0] m_data;
    bit           m_rdy, m_fe, m_ov;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_bits.delete();
        m_data = '0;
        m_rdy = 1'b0;
        m_fe = 1'b0;
        m_ov = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit b, input bit rd);
        bit           load;
        logic [W-1:0] word;
        load = 1'b0;
        word = '0;
        if (s) begin
            if (!m_in_frame) begin
                if (!b) begin
                    m_in_frame = 1'b1;
                    m_bits.delete();
                    m_fe = 1'b0;
                end
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == W + 1) begin
                    for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
                    if (m_bits[W]) load = 1'b1;
                    else m_fe = 1'b1;
                    m_in_frame = 1'b0;
                end
            end
        end
        if (load) begin
            m_ov = rd ? 1'b0 : (m_ov | m_rdy);
            m_rdy = 1'b1;
            m_data = word;
        end else if (rd) begin
            m_rdy = 1'b0;
            m_ov = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("rx_data", 32'(rx_data), 32'(m_data));
            chk("data_ready", 32'(data_ready), 32'(m_rdy));
            chk("framing_error", 32'(framing_error), 32'(m_fe));
            chk("overrun_error", 32'(overrun_error), 32'(m_ov));
        end
    end

    // One clock with the given inputs; serial_in is randomized when unsampled.
    task automatic cyc(input bit s, input bit b, input bit rd);
        shift_strobe = s;
        serial_in = s ? b : 1'($urandom);
        data_read = rd;
        @(posedge clk);
        model_step(s, b, rd);
        #1;
        shift_strobe = 1'b0;
        serial_in = 1'b1;
        data_read = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input bit stop, input int gap, input bit rd_at_stop);
        cyc(1'b1, 1'b0, 1'b0);
        repeat (gap) cyc(1'b0, 1'b1, 1'b0);
        for (int i = W - 1; i >= 0; i--) begin
            cyc(1'b1, d[i], 1'b0);
            repeat (gap) cyc(1'b0, 1'b1, 1'b0);
        end
        cyc(1'b1, stop, rd_at_stop);
    endtask

    task automatic flags(input string nm, input logic [W-1:0] d, input bit rdy, input bit fe, input bit ov);
        chk({nm, ".rx_data"}, 32'(rx_data), 32'(d));
        chk({nm, ".data_ready"}, 32'(data_ready), 32'(rdy));
        chk({nm, ".framing_error"}, 32'(framing_error), 32'(fe));
        chk({nm, ".overrun_error"}, 32'(overrun_error), 32'(ov));
    endtask

    initial begin
        logic [W-1:0] rd_word;
        model_reset();
        #12;
        flags("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        checking = 1'b1;
        @(posedge clk);
        #1;

        // 0xA5 via the explicit bit list 0,1,0,1,0,0,1,0,1,1
        send_frame(8'hA5, 1'b1, 0, 1'b0);
        flags("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        flags("a5_read", 8'hA5, 1'b0, 1'b0, 1'b0);

        // Good 0x3C then 0xA5 with a low stop bit
        send_frame(8'h3C, 1'b1, 1, 1'b0);
        send_frame(8'hA5, 1'b0, 0, 1'b0);
        flags("framing", 8'h3C, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("fe_survives_read", 32'(framing_error), 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("fe_cleared_by_start", 32'(framing_error), 32'd0);
        repeat (W) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        flags("ff_with_read", 8'hFF, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);

        // Overrun: 0x0F then 0xF0 with no read
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        send_frame(8'hF0, 1'b1, 0, 1'b0);
        flags("overrun", 8'hF0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        flags("overrun_read", 8'hF0, 1'b0, 1'b0, 1'b0);

        // Read on the exact load cycle
        send_frame(8'h0F, 1'b1, 0, 1'b0);
        send_frame(8'hF0, 1'b1, 0, 1'b1);
        flags("read_at_load", 8'hF0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset after 4 data bits
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'($urandom), 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        flags("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send_frame(8'h81, 1'b1, 0, 1'b0);
        flags("after_reset", 8'h81, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);

        // Idle-high strobes, then 0x00 with three idle clocks between strobes
        repeat (20) cyc(1'b1, 1'b1, 1'b0);
        flags("idle", 8'h81, 1'b0, 1'b0, 1'b0);
        send_frame(8'h00, 1'b1, 3, 1'b0);
        flags("zero_gapped", 8'h00, 1'b1, 1'b0, 1'b0);

        // Random frames with random gaps, stops and reads
        for (int k = 0; k < 60; k++) begin
            rd_word = W'($urandom);
            send_frame(rd_word, ($urandom_range(0, 4) != 0), $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) cyc(1'($urandom), 1'b1, ($urandom_range(0, 2) == 0));
        end
        // Unstructured random line activity
        for (int k = 0; k < 1500; k++) begin
            cyc(($urandom_range(0, 1) == 1), 1'($urandom), ($urandom_range(0, 5) == 0));
        end

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
